systolic_skew_feeder: RTL and testbench
=======================================

# systolic_skew_feeder

Parametrised operand feeder for the systolic matrix-multiply array. It accepts one ROWS×DEPTH operand matrix per handshake and holds it in a buffer. It then streams that matrix into the array edge as ROWS+DEPTH-1 diagonally skewed beats, with lane t delayed t beats, under valid/ready backpressure. Optional per-matrix element-order reversal and an optional second buffer for zero-bubble back-to-back matrices.

## Interface
- WIDTH, 8, bits per element
- ROWS, 4, output lanes (array edge length)
- DEPTH, 4, elements per lane (inner dimension)
- clock  in  1  clock
- nreset  in  1  asynchronous, active-low reset
- in_valid  in  1  matrix offered
- in_ready  out  1  feeder can accept a matrix
- in_mat  in  WIDTH × [ROWS][DEPTH] unpacked  operand matrix; row t feeds lane t
- in_rev  in  1  reverse element order within each lane for this matrix
- out_valid  out  1  beat present
- out_ready  in  1  array consumes beat
- out_data  out  ROWS*WIDTH  lane t at bits [t*WIDTH +: WIDTH]
- out_last  out  1  final beat of current matrix
- busy  out  1  a matrix is streaming or buffered

## Operation
- BEATS = ROWS+DEPTH-1. Beat counter k runs 0..BEATS-1.
- Lane t at beat k: e = k-t. If 0 ≤ e < DEPTH, output M[t][e], or M[t][DEPTH-1-e] when rev is latched. Otherwise output 0.
- in_rev is sampled together with in_mat on acceptance and stays fixed for that matrix.
- FSM states:
  - IDLE: in_ready=1. Acceptance loads the active buffer and sets k=0. Next state STREAM.
  - STREAM: out_valid=1. A beat transfers on out_valid&&out_ready, which increments k. When the transferred beat has k=BEATS-1:
    - a buffered matrix is pending: promote it to active, set k=0, stay in STREAM;
    - no matrix pending: go to IDLE.
- out_last = out_valid && k==BEATS-1.
- out_data is forced to 0 whenever out_valid=0.
- busy = (state==STREAM) || shadow buffer full.
- Counter width is $clog2(BEATS+1). There is no wrap beyond BEATS-1.
- Reset (async, any time, including mid-stream):
  - state IDLE, k=0, buffers marked empty;
  - in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0;
  - the partially streamed matrix is discarded.

## Timing
- Matrix accepted at edge N: beat 0 is valid from edge N+1, giving 1 cycle of latency.
- When out_ready is held high, beats are contiguous: BEATS cycles per matrix.
- When out_ready is low, out_data, out_last and k hold stable.
- Single buffer: after the last beat transfers at edge M, in_ready=1 from M+1, and the next matrix's beat 0 appears at M+2 at the earliest.
- Double buffer: the last beat of matrix A is followed in the very next cycle by beat 0 of the pending matrix B, with no bubble.
- If acceptance and the last-beat transfer occur in the same cycle:
  - double buffer: the incoming matrix goes straight to active.
  - single buffer: cannot occur, because in_ready=0 in STREAM.

## Configuration
- SKEW_DOUBLE_BUFFER_EN defined:
  - a shadow buffer is present;
  - in_ready = !shadow_full in STREAM and 1 in IDLE;
  - one matrix can be accepted while another streams.
- SKEW_DOUBLE_BUFFER_EN undefined:
  - single buffer only;
  - in_ready = (state==IDLE);
  - busy == (state==STREAM).

## Structure
- Shared package systolic_pkg holds:
  - `elem_t` (logic [WIDTH-1:0]);
  - the function `skew_beats(rows, depth)` returning rows+depth-1;
  - the FSM enum `skew_state_e` {IDLE, STREAM}.
- Sub-module skew_buffer holds one ROWS×DEPTH matrix plus its rev flag:
  - ports: load, in_mat, in_rev, k;
  - output: the selected skewed lane vector.
- skew_buffer is instantiated once, or twice under SKEW_DOUBLE_BUFFER_EN. The feeder muxes the active instance to out_data.

## Test plan
All scenarios use WIDTH=4, ROWS=3, DEPTH=3 and M = [[1,2,3],[7,6,5],[8,9,4]], with out_ready=1 unless stated.
- Forward order, in_rev=0 -> out_data = 0x001, 0x072, 0x863, 0x950, 0x400 on 5 consecutive cycles. out_last is high only on 0x400. in_ready returns 1 the cycle after.
- Reversed order, in_rev=1 -> out_data = 0x003, 0x052, 0x461, 0x970, 0x800.
- Backpressure: out_ready=0 for 3 cycles while beat 0x863 is presented -> 0x863 is held 4 cycles, then 0x950 follows. There are no duplicated or dropped beats.
- Reset mid-stream: nreset asserted during beat 0x072 -> out_valid=0, out_data=0, in_ready=1 immediately. A fresh M after release restarts at 0x001.
- SKEW_DOUBLE_BUFFER_EN, two matrices with in_valid held high:
  - second matrix is the reversed M;
  - in_ready=1 during the first stream, then 0 once the shadow buffer is full;
  - 10 contiguous beats: 0x001…0x400 followed directly by 0x003…0x800;
  - out_last is high twice.
- Without the macro, the same two-matrix stimulus -> second matrix accepted the cycle after 0x400, with one idle cycle (out_valid=0, out_data=0) between the two streams.

Source files
------------

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types for the systolic operand feeder (package systolic_pkg).
//   elem_t       : one matrix element at the default element width
//   skew_state_e : feeder FSM states
//   skew_beats() : number of skewed beats needed to stream a rows x depth matrix
package systolic_pkg;

  localparam int unsigned ELEM_WIDTH = 8;

  typedef logic [ELEM_WIDTH-1:0] elem_t;

  typedef enum logic {
    IDLE,
    STREAM
  } skew_state_e;

  function automatic int unsigned skew_beats(input int unsigned rows, input int unsigned depth);
    return rows + depth - 1;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Handshake bundle between a matrix producer and the systolic skew feeder.
//   in_valid/in_ready   : matrix handshake, in_mat/in_rev qualified by it
//   out_valid/out_ready : beat handshake toward the array edge
//   out_data            : lane t at bits [t*WIDTH +: WIDTH]
//   out_last            : final beat of the current matrix
//   busy                : a matrix is streaming or buffered
// Modports: master = producer/consumer side, slave = feeder side.
interface systolic_skew_feeder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned DEPTH = 4
);

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_mat [ROWS][DEPTH];
  logic                    in_rev;
  logic                    out_valid;
  logic                    out_ready;
  logic [ROWS*WIDTH-1:0]   out_data;
  logic                    out_last;
  logic                    busy;

  modport master (
    output in_valid, in_mat, in_rev, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_mat, in_rev, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/systolic_skew_feeder_skew_buffer.sv
// skew_buffer: holds one ROWS x DEPTH operand matrix and its reverse flag,
// and presents the diagonally skewed lane vector for beat index k.
//   clock, nreset : clock, asynchronous active-low reset
//   load          : capture in_mat/in_rev
//   in_mat, in_rev: matrix and element-order flag to capture
//   k             : current beat index
//   lanes_o       : lane t at [t*WIDTH +: WIDTH]; zero outside the lane's window
module skew_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned KW    = 3
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      in_mat [ROWS][DEPTH],
  input  logic                  in_rev,
  input  logic [KW-1:0]         k,
  output logic [ROWS*WIDTH-1:0] lanes_o
);

  logic [WIDTH-1:0] mat_q [ROWS][DEPTH];
  logic             rev_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned t = 0; t < ROWS; t++)
        for (int unsigned d = 0; d < DEPTH; d++)
          mat_q[t][d] <= '0;
      rev_q <= 1'b0;
    end else if (load) begin
      mat_q <= in_mat;
      rev_q <= in_rev;
    end
  end

  // Lane t shows element d exactly when k == t + d.
  always_comb begin
    lanes_o = '0;
    for (int unsigned t = 0; t < ROWS; t++)
      for (int unsigned d = 0; d < DEPTH; d++)
        if (32'(k) == t + d)
          lanes_o[t*WIDTH +: WIDTH] = rev_q ? mat_q[t][DEPTH-1-d] : mat_q[t][d];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: accepts one ROWS x DEPTH matrix per handshake and
// streams it as ROWS+DEPTH-1 diagonally skewed beats (lane t delayed t beats).
//   clock, nreset : clock, asynchronous active-low reset
//   bus (slave)   : in_valid/in_ready/in_mat/in_rev, out_valid/out_ready/
//                   out_data/out_last, busy
// Build option: define SKEW_DOUBLE_BUFFER_EN for a shadow buffer that lets
// the next matrix be accepted while one streams (zero-bubble back-to-back).
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic                   clock,
  input logic                   nreset,
  systolic_skew_feeder_if.slave bus
);

  localparam int unsigned   BEATS  = skew_beats(ROWS, DEPTH);
  localparam int unsigned   KW     = $clog2(BEATS + 1);
  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

  skew_state_e           state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  accept, xfer, last_xfer, pending;
  logic [ROWS*WIDTH-1:0] lanes;

`ifdef SKEW_DOUBLE_BUFFER_EN
  // Ping-pong pair: act_q selects the streaming buffer, the other is shadow.
  logic                  act_q, act_d;
  logic                  shadow_full_q, shadow_full_d;
  logic                  tgt;
  logic [1:0]            load;
  logic [ROWS*WIDTH-1:0] lanes_b [2];

  assign tgt     = (state_q == IDLE) ? act_q : ~act_q;
  assign load[0] = accept && !tgt;
  assign load[1] = accept && tgt;

  for (genvar i = 0; i < 2; i++) begin : g_buf
    skew_buffer #(.WIDTH(WIDTH), .ROWS(ROWS), .DEPTH(DEPTH), .KW(KW)) u_buf (
      .clock   (clock),
      .nreset  (nreset),
      .load    (load[i]),
      .in_mat  (bus.in_mat),
      .in_rev  (bus.in_rev),
      .k       (k_q),
      .lanes_o (lanes_b[i])
    );
  end

  assign lanes        = lanes_b[act_q];
  assign bus.in_ready = (state_q == IDLE) || !shadow_full_q;
  assign bus.busy     = (state_q == STREAM) || shadow_full_q;
  // A matrix arriving on the last-beat cycle counts as pending and is promoted at once.
  assign pending      = shadow_full_q || accept;
`else
  skew_buffer #(.WIDTH(WIDTH), .ROWS(ROWS), .DEPTH(DEPTH), .KW(KW)) u_buf (
    .clock   (clock),
    .nreset  (nreset),
    .load    (accept),
    .in_mat  (bus.in_mat),
    .in_rev  (bus.in_rev),
    .k       (k_q),
    .lanes_o (lanes)
  );

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q == STREAM);
  assign pending      = 1'b0;
`endif

  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == STREAM);
  assign xfer         = bus.out_valid && bus.out_ready;
  assign last_xfer    = xfer && (k_q == K_LAST);
  assign bus.out_data = bus.out_valid ? lanes : '0;
  assign bus.out_last = bus.out_valid && (k_q == K_LAST);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
`ifdef SKEW_DOUBLE_BUFFER_EN
    act_d         = act_q;
    shadow_full_d = shadow_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = STREAM;
          k_d     = '0;
        end
      end
      STREAM: begin
        if (last_xfer) begin
          k_d = '0;
          if (!pending) state_d = IDLE;
`ifdef SKEW_DOUBLE_BUFFER_EN
          if (pending) begin
            act_d         = ~act_q;
            shadow_full_d = 1'b0;
          end
`endif
        end else begin
          if (xfer) k_d = k_q + 1'b1;
`ifdef SKEW_DOUBLE_BUFFER_EN
          if (accept) shadow_full_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      k_q     <= '0;
`ifdef SKEW_DOUBLE_BUFFER_EN
      act_q         <= 1'b0;
      shadow_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
`ifdef SKEW_DOUBLE_BUFFER_EN
      act_q         <= act_d;
      shadow_full_q <= shadow_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Testbench for systolic_skew_feeder with WIDTH=4, ROWS=3, DEPTH=3.
// Directed vector tables, a mid-stream reset sequence, and a randomized run
// compared against a beat-queue reference model.
module tb_systolic_skew_feeder;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned ROWS  = 3;
  localparam int unsigned DEPTH = 3;
  localparam int          BEATS = ROWS + DEPTH - 1;
`ifdef SKEW_DOUBLE_BUFFER_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  typedef logic [WIDTH-1:0] mat_t [ROWS][DEPTH];

  typedef struct {
    logic        iv;
    logic        rev;
    logic        ordy;
    logic        ev;
    logic [11:0] ed;
    logic        el;
    logic        eir;
    logic        eb;
  } vec_t;

  typedef struct {
    logic [11:0] d;
    logic        last;
  } beat_t;

  logic clock;
  logic nreset;

  systolic_skew_feeder_if #(.WIDTH(WIDTH), .ROWS(ROWS), .DEPTH(DEPTH)) bus ();

  systolic_skew_feeder #(.WIDTH(WIDTH), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    total  = 0;
  int    passes = 0;
  vec_t  tv[$];
  beat_t q[$];
  int    outstanding;
  mat_t  M;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [11:0] ed,
                            input logic el, input logic eir, input logic eb);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(ed));
    chk({tag, ".out_last"},  32'(bus.out_last),  32'(el));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(eir));
    chk({tag, ".busy"},      32'(bus.busy),      32'(eb));
  endtask

  function automatic vec_t mk(input logic iv, input logic rev, input logic ordy, input logic ev,
                              input logic [11:0] ed, input logic el, input logic eir, input logic eb);
    vec_t v;
    v.iv = iv; v.rev = rev; v.ordy = ordy; v.ev = ev;
    v.ed = ed; v.el = el; v.eir = eir; v.eb = eb;
    return v;
  endfunction

  // Called at a negedge; leaves the DUT idle and out of reset at a negedge.
  task automatic do_reset();
    nreset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rev    = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_mat    = M;
    repeat (2) @(negedge clock);
    check_outs("reset", 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    nreset = 1'b1;
  endtask

  task automatic run_tv(input string tag);
    for (int i = 0; i < tv.size(); i++) begin
      bus.in_valid  = tv[i].iv;
      bus.in_rev    = tv[i].rev;
      bus.out_ready = tv[i].ordy;
      bus.in_mat    = M;
      @(negedge clock);
      check_outs($sformatf("%s[%0d]", tag, i), tv[i].ev, tv[i].ed, tv[i].el, tv[i].eir, tv[i].eb);
    end
    tv.delete();
  endtask

  // Reference: lane t at beat k carries element k-t when that index is in range.
  function automatic void push_beats(input mat_t m, input logic rev);
    for (int k = 0; k < BEATS; k++) begin
      beat_t b;
      b.d = '0;
      for (int t = 0; t < int'(ROWS); t++) begin
        int e;
        e = k - t;
        if (e >= 0 && e < int'(DEPTH))
          b.d[t*WIDTH +: WIDTH] = rev ? m[t][int'(DEPTH)-1-e] : m[t][e];
      end
      b.last = (k == BEATS - 1);
      q.push_back(b);
    end
  endfunction

  initial begin
    M = '{'{4'd1, 4'd2, 4'd3}, '{4'd7, 4'd6, 4'd5}, '{4'd8, 4'd9, 4'd4}};
    nreset = 1'b0;
    @(negedge clock);

    // Forward order
    do_reset();
    tv.push_back(mk(1, 0, 1, 1, 12'h001, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h072, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h863, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h950, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h400, 1, DBL, 1));
    tv.push_back(mk(0, 0, 1, 0, 12'h000, 0, 1,   0));
    run_tv("fwd");

    // Reversed order
    do_reset();
    tv.push_back(mk(1, 1, 1, 1, 12'h003, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h052, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h461, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h970, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h800, 1, DBL, 1));
    tv.push_back(mk(0, 0, 1, 0, 12'h000, 0, 1,   0));
    run_tv("rev");

    // Backpressure while 0x863 is presented
    do_reset();
    tv.push_back(mk(1, 0, 1, 1, 12'h001, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h072, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h863, 0, DBL, 1));
    tv.push_back(mk(0, 0, 0, 1, 12'h863, 0, DBL, 1));
    tv.push_back(mk(0, 0, 0, 1, 12'h863, 0, DBL, 1));
    tv.push_back(mk(0, 0, 0, 1, 12'h863, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h950, 0, DBL, 1));
    tv.push_back(mk(0, 0, 1, 1, 12'h400, 1, DBL, 1));
    tv.push_back(mk(0, 0, 1, 0, 12'h000, 0, 1,   0));
    run_tv("bp");

    // Two matrices back to back, second reversed
    do_reset();
`ifdef SKEW_DOUBLE_BUFFER_EN
    tv.push_back(mk(1, 0, 1, 1, 12'h001, 0, 1, 1));
    tv.push_back(mk(1, 1, 1, 1, 12'h072, 0, 0, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h863, 0, 0, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h950, 0, 0, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h400, 1, 0, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h003, 0, 1, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h052, 0, 1, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h461, 0, 1, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h970, 0, 1, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h800, 1, 1, 1));
    tv.push_back(mk(0, 0, 1, 0, 12'h000, 0, 1, 0));
`else
    tv.push_back(mk(1, 0, 1, 1, 12'h001, 0, 0, 1));
    tv.push_back(mk(1, 1, 1, 1, 12'h072, 0, 0, 1));
    tv.push_back(mk(1, 1, 1, 1, 12'h863, 0, 0, 1));
    tv.push_back(mk(1, 1, 1, 1, 12'h950, 0, 0, 1));
    tv.push_back(mk(1, 1, 1, 1, 12'h400, 1, 0, 1));
    tv.push_back(mk(1, 1, 1, 0, 12'h000, 0, 1, 0));
    tv.push_back(mk(1, 1, 1, 1, 12'h003, 0, 0, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h052, 0, 0, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h461, 0, 0, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h970, 0, 0, 1));
    tv.push_back(mk(0, 1, 1, 1, 12'h800, 1, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 12'h000, 0, 1, 0));
`endif
    run_tv("two");

    // Reset asserted mid-stream, then a fresh matrix
    do_reset();
    bus.in_valid = 1'b1; bus.in_rev = 1'b0; bus.out_ready = 1'b1;
    @(negedge clock);
    chk("mid.beat0", 32'(bus.out_data), 32'h001);
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("mid.beat1", 32'(bus.out_data), 32'h072);
    nreset = 1'b0;
    #1;
    check_outs("mid.rst", 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    nreset = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clock);
    check_outs("mid.restart0", 1'b1, 12'h001, 1'b0, DBL, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("mid.restart1", 32'(bus.out_data), 32'h072);

    // Randomized traffic against the beat-queue model
    do_reset();
    q.delete();
    outstanding = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      mat_t  m;
      logic  iv, rev, ordy, exp_ir, acc, xf;
      beat_t fb;
      fb.d = '0; fb.last = 1'b0;
      if (q.size() > 0) fb = q[0];
      exp_ir = DBL ? (outstanding < 2) : (outstanding == 0);
      check_outs("rnd", q.size() > 0, fb.d, fb.last, exp_ir, outstanding > 0);

      for (int t = 0; t < int'(ROWS); t++)
        for (int d = 0; d < int'(DEPTH); d++)
          m[t][d] = WIDTH'($urandom);
      iv   = ($urandom_range(0, 9) < 4);
      rev  = 1'($urandom);
      ordy = ($urandom_range(0, 9) < 7);
      bus.in_mat = m; bus.in_valid = iv; bus.in_rev = rev; bus.out_ready = ordy;

      acc = iv && exp_ir;
      xf  = (q.size() > 0) && ordy;
      if (xf) begin
        if (q[0].last) outstanding--;
        void'(q.pop_front());
      end
      if (acc) begin
        push_beats(m, rev);
        outstanding++;
      end
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
